// File: rtl/data_mem_bridge_if.sv
// Memory-side bus of the data bridge: split request (req/addr_ok) and response (data_ok/rdata).
// master = bridge, slave = data memory or cache/AXI bridge.
interface data_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// Purpose: MEM-stage one-shot access -> split req/addr_ok/data_ok transaction; kseg0/kseg1 map under DMEM_BRIDGE_ADDR_MAP_EN.
// Latency: data_req the cycle after cpu_en; d_stall low the cycle after data_ok (min 2 cycles).
// Backpressure: request fields held until addr_ok; result held in DONE while longest_stall is high.
module data_mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 cpu_en,
    input  logic [DATA_W/8-1:0]  cpu_wen,
    input  logic [1:0]           cpu_size,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    input  logic                 longest_stall,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 d_stall,
    data_mem_bridge_if.master    mem
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  req;
    logic                  stall;
    logic                  accept;
    logic                  rd_done;

    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [ADDR_W-1:0]     phys_addr;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = cpu_en;
                if (cpu_en) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem.data_addr_ok && mem.data_data_ok) begin
                    state_nxt = DONE;
                end else if (mem.data_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                stall = 1'b1;
                if (mem.data_data_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!longest_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = (state == IDLE) && cpu_en;
    // data_ok only counts once the address phase has been accepted
    assign rd_done = !wr_q && mem.data_data_ok &&
                     (((state == ADDR) && mem.data_addr_ok) || (state == DATA));

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cpu_rdata <= '0;
        end else begin
            if (accept) begin
                wr_q    <= |cpu_wen;
                size_q  <= cpu_size;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wstrb_q <= cpu_wen;
            end
            if (rd_done) begin
                cpu_rdata <= mem.data_rdata;
            end
        end
    end

`ifdef DMEM_BRIDGE_ADDR_MAP_EN
    // kseg0 (3'b100) and kseg1 (3'b101) share top bits 2'b10; both fold onto physical 0
    always_comb begin
        phys_addr = addr_q;
        if (addr_q[ADDR_W-1 -: 2] == 2'b10) begin
            phys_addr[ADDR_W-1 -: 3] = 3'b000;
        end
    end
`else
    assign phys_addr = addr_q;
`endif

    // reset must pull the stall low immediately even if cpu_en is still high
    assign d_stall        = stall && !rst;
    assign mem.data_req   = req;
    assign mem.data_wr    = wr_q;
    assign mem.data_size  = size_q;
    assign mem.data_addr  = phys_addr;
    assign mem.data_wdata = wdata_q;
    assign mem.data_wstrb = wstrb_q;

endmodule
